// File: rtl/cpu_pkg.sv
// cpu_pkg: shared instruction-field constants and sizing helpers for the loader
package cpu_pkg;
  localparam int OPCODE_W = 4;
  localparam int OPCODE_LSB = 0;
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int beats_of(input int instr_w, input int din_w);
    return instr_w / din_w;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two circular FIFO with flush; push while full is accepted only alongside a pop
module sync_fifo
  import cpu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int AW = clog2_min1(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic wr, rd;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign rd = pop & ~empty;
  assign wr = push & (~full | rd);
  assign rdata = empty ? '0 : mem[rptr];
  // pointers and occupancy; flush empties the queue without touching storage
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      wptr <= wptr + AW'(wr);
      rptr <= rptr + AW'(rd);
      count <= count + CW'(wr) - CW'(rd);
    end
  end
  // storage write
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= wdata;
  end
endmodule

// File: rtl/instr_loader.sv
// instr_loader: button-stepped switch sampler building instruction words into a FIFO; optional debounce via INSTR_LOADER_DEBOUNCE_EN
module instr_loader
  import cpu_pkg::*;
#(
  parameter int DIN_W = 8,
  parameter int INSTR_W = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  localparam int BEATS = beats_of(INSTR_W, DIN_W),
  localparam int BW = clog2_min1(BEATS),
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DIN_W-1:0]   din,
  input  logic               btn_level,
  input  logic               clear,
  output logic [INSTR_W-1:0] instr_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               btn_edge,
  output logic [BW-1:0]      beat_idx,
  output logic [CW-1:0]      fifo_count,
  output logic               overflow
);
  logic sync0, sync1, btn_prev, deb_level, live, armed;
  logic [INSTR_W-1:0] asm_q, word;
  logic last, push, pop, full, empty;
`ifdef INSTR_LOADER_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [DW-1:0] db_cnt;
  logic db_level;
  // accept a level change only after it has persisted DEBOUNCE_CYCLES cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_cnt <= '0;
      db_level <= 1'b0;
    end else if (sync1 != db_level) begin
      db_cnt <= (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) ? '0 : db_cnt + 1'b1;
      if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) db_level <= sync1;
    end else begin
      db_cnt <= '0;
    end
  end
  assign deb_level = db_level;
`else
  assign deb_level = sync1;
`endif
  // a button held through reset must be released before it can count as a press
  assign btn_edge = deb_level & ~btn_prev & armed;
  assign last = beat_idx == BW'(BEATS - 1);
  assign push = btn_edge & last & ~clear;
  assign pop = instr_valid & instr_ready & ~clear;
  assign instr_valid = ~empty;
  // current beat merged into the partial word, so the last beat pushes in the same edge
  always_comb begin
    word = asm_q;
    word[beat_idx*DIN_W +: DIN_W] = din;
  end
  // synchroniser, edge history and arming; clear leaves these untouched
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
      btn_prev <= 1'b0;
      live <= 1'b0;
      armed <= 1'b0;
    end else begin
      sync0 <= btn_level;
      sync1 <= sync0;
      btn_prev <= deb_level;
      live <= 1'b1;
      armed <= armed | (live & ~sync0 & ~sync1 & ~deb_level);
    end
  end
  // beat assembly and sticky drop flag
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      beat_idx <= '0;
      asm_q <= '0;
      overflow <= 1'b0;
    end else begin
      if (btn_edge) begin
        beat_idx <= last ? '0 : beat_idx + 1'b1;
        asm_q <= last ? '0 : word;
      end
      if (push && full && !pop) overflow <= 1'b1;
    end
  end
  sync_fifo #(.WIDTH(INSTR_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .flush(clear),
    .push(push),
    .pop(pop),
    .wdata(word),
    .rdata(instr_data),
    .count(fifo_count),
    .full(full),
    .empty(empty)
  );
endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Parametrised successor to the two-press DIP-switch instruction loader in the top level.
- Synchronises the external push button, detects a rising edge, and assembles BEATS = INSTR_W/DIN_W switch samples into one instruction word.
- Queues completed words in a small FIFO and hands them to cpu_core over a valid/ready handshake, so the core is decoupled from operator timing.

Parameters:
- DIN_W, 8, width of the switch bus sampled per press.
- INSTR_W, 16, assembled instruction width; must be an integer multiple of DIN_W and at least DIN_W.
- FIFO_DEPTH, 4, number of queued instructions; power of two, at least 2.
- DEBOUNCE_CYCLES, 16, stable cycles required before a button level change is accepted (used only with the optional feature).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- din  in  DIN_W  switch data, sampled on accepted press.
- btn_level  in  1  raw asynchronous push-button level.
- clear  in  1  synchronous flush: drops partial beats and FIFO contents.
- instr_data  out  INSTR_W  head-of-FIFO instruction.
- instr_valid  out  1  FIFO non-empty.
- instr_ready  in  1  consumer accepts the head word when high together with instr_valid.
- btn_edge  out  1  one-cycle accepted-press pulse, for the core.
- beat_idx  out  clog2(BEATS), minimum 1 bit  index of the next beat to be captured.
- fifo_count  out  clog2(FIFO_DEPTH)+1  occupancy.
- overflow  out  1  sticky flag: a completed word was dropped because the FIFO was full.

Behaviour:
- Reset values (rst_n low at a clock edge): all outputs 0, including instr_data, beat_idx, fifo_count and overflow; sync flops 0; FIFO empty.
- Reset mid-assembly discards all partial beats.
- Synchroniser: two flops, sync0 and then sync1, followed by btn_prev.
- btn_edge = debounced_level & ~btn_prev, combinational from registers.
- Without debounce, the debounced level is sync1.
- Press latency: btn_level rises and is held. sync1 goes high after the 2nd edge. btn_edge is high during the following cycle. The beat is captured at the 3rd edge.
- Beat capture: at an edge where btn_edge=1, din is written into bits [beat_idx*DIN_W +: DIN_W] of the assembly register and beat_idx increments.
- Beat 0 occupies the low bits, so bits [3:0] of beat 0 are the opcode field.
- Last beat (beat_idx == BEATS-1): the assembled word, including the current din, is pushed to the FIFO in the same edge, and beat_idx wraps to 0.
- FIFO push succeeds if fifo_count < FIFO_DEPTH, or if a pop happens in the same cycle.
- Otherwise the word is dropped, overflow is set (sticky until clear or reset), and beat_idx still wraps to 0.
- Pop: instr_valid & instr_ready at an edge advances the read pointer.
- Simultaneous push and pop leaves the count unchanged.
- instr_valid is never high when the FIFO is empty.
- Push-to-output latency: instr_valid is high in the cycle after the push edge. instr_data is stable while instr_valid=1 and instr_ready=0.
- Pointers wrap modulo FIFO_DEPTH.
- clear has priority over capture, push and pop in the same cycle. It sets beat_idx=0, fifo_count=0, overflow=0 and instr_valid=0. Synchroniser state is kept.
- BEATS=1: beat_idx stays 0, and every accepted press pushes one word.

Optional Feature:
- Macro INSTR_LOADER_DEBOUNCE_EN.
- Defined: a counter tracks sync1. While sync1 differs from the debounced level, the counter increments; otherwise it resets to 0.
- When the counter reaches DEBOUNCE_CYCLES-1, the debounced level takes sync1 and the counter resets.
- Capture latency therefore becomes 2 + DEBOUNCE_CYCLES + 1 edges.
- Glitches shorter than DEBOUNCE_CYCLES cycles produce no btn_edge.
- Not defined: no counter, and the debounced level is sync1 (behaviour as in the press-latency rule above).

Decomposition:
- Shared package cpu_pkg holds:
  - OPCODE_W=4;
  - the beat-0 opcode field position;
  - the function used to derive BEATS and the counter widths.
- One natural sub-module: sync_fifo, parametrised by WIDTH and DEPTH.
  - Ports: push, pop, wdata, rdata, count, full, empty, flush.
  - instr_loader instantiates sync_fifo; the synchroniser, debounce and assembler logic stay in the parent.

Test Plan:
- Defaults, debounce off: press with din=8'hA3, then press with din=8'h5C -> beat_idx goes 0, 1, 0; instr_valid rises one cycle after the 2nd capture with instr_data=16'h5CA3; opcode field = 4'h3.
- instr_ready held 0, 10 presses (5 words) -> fifo_count=4 and overflow=1; first four words pop in order after instr_ready=1; the 5th word is absent.
- FIFO full, last beat captured in the same cycle as a pop -> push accepted, fifo_count stays 4, overflow stays 0.
- One press (beat_idx=1), then clear=1 for one cycle -> beat_idx=0, fifo_count=0; the next two presses with 8'h11, 8'h22 yield 16'h2211.
- rst_n low for 1 cycle between beats with btn_level held high -> all outputs 0 after the edge; no capture until btn_level falls and rises again.
- With INSTR_LOADER_DEBOUNCE_EN and DEBOUNCE_CYCLES=16: a 10-cycle pulse gives no btn_edge; a held press gives btn_edge on edge 2+16; capture on edge 19.
